// File: rtl/regfile_ckpt.sv
// regfile_ckpt: decode-stage register file with two combinational read ports,
// one write port, optional write-through bypass, optional hardwired-zero
// register 0 and a single-level checkpoint of the whole array for rollback.
module regfile_ckpt #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    localparam int AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr0,
    output logic [WIDTH-1:0] rd_data0,
    input  logic [AW-1:0]    rd_addr1,
    output logic [WIDTH-1:0] rd_data1,
    input  logic             ckpt_save,
    input  logic             ckpt_restore,
    output logic             ckpt_valid,
    output logic             err
);

    // Register count widened by one bit so an index can be compared against it
    localparam logic [AW:0] NUM_REGS_W = (AW + 1)'(NUM_REGS);

    logic [WIDTH-1:0] regs_q   [NUM_REGS];
    logic [WIDTH-1:0] regs_d   [NUM_REGS];
    logic [WIDTH-1:0] shadow_q [NUM_REGS];
    logic [WIDTH-1:0] shadow_d [NUM_REGS];
    logic             valid_q;
    logic             valid_d;
    logic             err_q;
    logic             err_d;

    logic wr_in_range;
    logic wr_to_zero;
    logic save_eff;
    logic restore_eff;
    logic save_restore_both;
    logic wr_eff;

    // Decode which of write / save / restore actually take effect this cycle
    always_comb begin
        wr_in_range       = ({1'b0, wr_addr} < NUM_REGS_W);
        wr_to_zero        = (ZERO_REG != 0) && (wr_addr == '0);
        save_restore_both = ckpt_save & ckpt_restore;
        save_eff          = ckpt_save & ~ckpt_restore;
        restore_eff       = ckpt_restore & ~ckpt_save & valid_q;
        wr_eff            = wr_en & wr_in_range & ~wr_to_zero & ~restore_eff;
        err_d             = (wr_en & ~wr_in_range)
                          | (ckpt_restore & ~valid_q)
                          | save_restore_both;
    end

    // Next array contents: restore wins over a write; the shadow captures the post-write image
    always_comb begin
        regs_d   = regs_q;
        shadow_d = shadow_q;
        valid_d  = valid_q | save_eff;
        if (restore_eff) begin
            regs_d = shadow_q;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_eff && (wr_addr == AW'(i))) begin
                    regs_d[i] = wr_data;
                end
            end
        end
        if (save_eff) begin
            shadow_d = regs_d;
        end
    end

    // Array, shadow and status flops, cleared asynchronously while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q   <= '{default: '0};
            shadow_q <= '{default: '0};
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            shadow_q <= shadow_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // Read ports: out-of-range and hardwired-zero reads give 0, bypass forwards same-cycle writes
    always_comb begin
        rd_data0 = '0;
        rd_data1 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!((ZERO_REG != 0) && (i == 0))) begin
                if (rd_addr0 == AW'(i)) begin
                    rd_data0 = regs_q[i];
                end
                if (rd_addr1 == AW'(i)) begin
                    rd_data1 = regs_q[i];
                end
            end
        end
        if ((BYPASS != 0) && wr_eff) begin
            if (rd_addr0 == wr_addr) begin
                rd_data0 = wr_data;
            end
            if (rd_addr1 == wr_addr) begin
                rd_data1 = wr_data;
            end
        end
    end

    assign ckpt_valid = valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_regfile_ckpt.sv
// tb_regfile_ckpt: two register-file configurations driven by shared stimulus
// (A: 6 regs, bypass, hardwired zero; B: 8 regs, no bypass) and checked every
// cycle against an array-based model, plus directed literal checks.
module tb_regfile_ckpt;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr0;
    logic [2:0]  rd_addr1;
    logic        ckpt_save;
    logic        ckpt_restore;
    logic [15:0] rd0 [2];
    logic [15:0] rd1 [2];
    logic        vld [2];
    logic        errs [2];

    int nChecks = 0;
    int nFails  = 0;
    bit checking = 0;

    // Model configuration and state, one slot per DUT
    int          nregs [2] = '{6, 8};
    bit          zr    [2] = '{1'b1, 1'b0};
    bit          byp   [2] = '{1'b1, 1'b0};
    logic [15:0] mreg  [2][8];
    logic [15:0] msh   [2][8];
    bit          mvalid [2];
    bit          merr   [2];

    regfile_ckpt #(.WIDTH(16), .NUM_REGS(6), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(rd0[0]), .rd_addr1(rd_addr1), .rd_data1(rd1[0]),
        .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
        .ckpt_valid(vld[0]), .err(errs[0])
    );

    regfile_ckpt #(.WIDTH(16), .NUM_REGS(8), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(rd0[1]), .rd_addr1(rd_addr1), .rd_data1(rd1[1]),
        .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
        .ckpt_valid(vld[1]), .err(errs[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelClear();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                mreg[k][i] = '0;
                msh[k][i]  = '0;
            end
            mvalid[k] = 1'b0;
            merr[k]   = 1'b0;
        end
    endtask

    function automatic bit modelWriteTakes(int k);
        int a;
        bit restoreTakes;
        a = int'(wr_addr);
        restoreTakes = ckpt_restore && !ckpt_save && mvalid[k];
        return wr_en && (a < nregs[k]) && !(zr[k] && a == 0) && !restoreTakes;
    endfunction

    function automatic logic [15:0] modelRead(int k, logic [2:0] addr);
        int a;
        a = int'(addr);
        if (a >= nregs[k]) return 16'h0000;
        if (zr[k] && a == 0) return 16'h0000;
        if (byp[k] && modelWriteTakes(k) && addr == wr_addr) return wr_data;
        return mreg[k][a];
    endfunction

    task automatic modelStep(int k);
        int a;
        bit restoreTakes;
        bit writeTakes;
        bit errNext;
        a = int'(wr_addr);
        restoreTakes = ckpt_restore && !ckpt_save && mvalid[k];
        writeTakes   = modelWriteTakes(k);
        errNext = (wr_en && a >= nregs[k]) || (ckpt_restore && !mvalid[k]) || (ckpt_save && ckpt_restore);
        if (restoreTakes) begin
            for (int i = 0; i < 8; i++) mreg[k][i] = msh[k][i];
        end else if (writeTakes) begin
            mreg[k][a] = wr_data;
        end
        if (ckpt_save && !ckpt_restore) begin
            for (int i = 0; i < 8; i++) msh[k][i] = mreg[k][i];
            mvalid[k] = 1'b1;
        end
        merr[k] = errNext;
    endtask

    // Advance the model at every rising edge using the inputs held over that edge
    always @(posedge clk) begin
        if (rst) begin
            modelStep(0);
            modelStep(1);
        end else begin
            modelClear();
        end
    end

    // Asynchronous reset clears the model immediately
    always @(negedge rst) modelClear();

    // Compare every DUT output against the model once per cycle, away from the active edge
    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("rd_data0[%0d]", k), rd0[k], modelRead(k, rd_addr0));
                checkOutput($sformatf("rd_data1[%0d]", k), rd1[k], modelRead(k, rd_addr1));
                checkOutput($sformatf("ckpt_valid[%0d]", k), {15'd0, vld[k]}, {15'd0, mvalid[k]});
                checkOutput($sformatf("err[%0d]", k), {15'd0, errs[k]}, {15'd0, merr[k]});
            end
        end
    end

    task automatic applyStimulus(input bit we, input logic [2:0] wa, input logic [15:0] wd,
                                 input logic [2:0] ra0, input logic [2:0] ra1,
                                 input bit sv, input bit rs);
        @(posedge clk);
        #2;
        wr_en        = we;
        wr_addr      = wa;
        wr_data      = wd;
        rd_addr0     = ra0;
        rd_addr1     = ra1;
        ckpt_save    = sv;
        ckpt_restore = rs;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr0 = '0; rd_addr1 = '0;
        ckpt_save = 1'b0; ckpt_restore = 1'b0;
        modelClear();
        #2;
        checking = 1;
        #1;
        checkOutput("reset rd0 A", rd0[0], 16'h0000);
        checkOutput("reset valid B", {15'd0, vld[1]}, 16'h0000);
        checkOutput("reset err A", {15'd0, errs[0]}, 16'h0000);
        @(negedge clk); #1 rst = 1'b1;

        // Write reg3 and read it in the same cycle, then the next cycle
        applyStimulus(1, 3'd3, 16'hBEEF, 3'd3, 3'd0, 0, 0);
        checkOutput("bypass A", rd0[0], 16'hBEEF);
        checkOutput("no bypass B", rd0[1], 16'h0000);
        applyStimulus(0, 3'd0, 16'h0000, 3'd3, 3'd0, 0, 0);
        checkOutput("stored A", rd0[0], 16'hBEEF);
        checkOutput("stored B", rd0[1], 16'hBEEF);

        // Save with same-cycle write, overwrite, then restore
        applyStimulus(1, 3'd1, 16'h1111, 3'd1, 3'd0, 1, 0);
        applyStimulus(1, 3'd1, 16'h2222, 3'd1, 3'd0, 0, 0);
        applyStimulus(0, 3'd0, 16'h0000, 3'd1, 3'd0, 0, 1);
        checkOutput("pre-restore B", rd0[1], 16'h2222);
        applyStimulus(0, 3'd0, 16'h0000, 3'd1, 3'd0, 0, 0);
        checkOutput("restored A", rd0[0], 16'h1111);
        checkOutput("restored B", rd0[1], 16'h1111);
        checkOutput("valid after restore A", {15'd0, vld[0]}, 16'h0001);

        // Address 7: out of range for A, legal for B
        applyStimulus(1, 3'd7, 16'h5555, 3'd0, 3'd7, 0, 0);
        checkOutput("oob read A", rd1[0], 16'h0000);
        applyStimulus(0, 3'd0, 16'h0000, 3'd0, 3'd7, 0, 0);
        checkOutput("oob err A", {15'd0, errs[0]}, 16'h0001);
        checkOutput("in-range err B", {15'd0, errs[1]}, 16'h0000);
        checkOutput("reg7 B", rd1[1], 16'h5555);

        // Writes to register 0
        applyStimulus(1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 0, 0);
        checkOutput("zero bypass A", rd0[0], 16'h0000);
        applyStimulus(0, 3'd0, 16'h0000, 3'd0, 3'd0, 0, 0);
        checkOutput("zero err A", {15'd0, errs[0]}, 16'h0000);
        checkOutput("zero read A", rd0[0], 16'h0000);
        checkOutput("reg0 B", rd0[1], 16'hFFFF);

        // Save+restore together: error, write still lands, shadow untouched
        applyStimulus(1, 3'd2, 16'h00AA, 3'd1, 3'd2, 1, 1);
        applyStimulus(0, 3'd0, 16'h0000, 3'd1, 3'd2, 0, 0);
        checkOutput("both err A", {15'd0, errs[0]}, 16'h0001);
        checkOutput("both err B", {15'd0, errs[1]}, 16'h0001);
        checkOutput("both write B", rd1[1], 16'h00AA);
        applyStimulus(0, 3'd0, 16'h0000, 3'd1, 3'd2, 0, 1);
        applyStimulus(0, 3'd0, 16'h0000, 3'd1, 3'd2, 0, 0);
        checkOutput("shadow reg1 A", rd0[0], 16'h1111);
        checkOutput("shadow reg2 B", rd1[1], 16'h0000);

        // Asynchronous reset in the middle of a cycle
        applyStimulus(0, 3'd0, 16'h0000, 3'd1, 3'd3, 0, 0);
        rst = 1'b0;
        #1;
        checkOutput("async rd0 B", rd0[1], 16'h0000);
        checkOutput("async rd1 A", rd1[0], 16'h0000);
        checkOutput("async valid A", {15'd0, vld[0]}, 16'h0000);
        @(negedge clk); #1 rst = 1'b1;

        // Restore with nothing saved: error, write proceeds
        applyStimulus(1, 3'd2, 16'h00AA, 3'd2, 3'd1, 0, 1);
        checkOutput("invalid restore bypass A", rd0[0], 16'h00AA);
        applyStimulus(0, 3'd0, 16'h0000, 3'd2, 3'd1, 0, 0);
        checkOutput("invalid restore err B", {15'd0, errs[1]}, 16'h0001);
        checkOutput("invalid restore reg2 B", rd0[1], 16'h00AA);
        checkOutput("invalid restore reg1 A", rd1[0], 16'h0000);
        checkOutput("invalid restore valid B", {15'd0, vld[1]}, 16'h0000);

        // Randomized traffic checked by the model
        for (int n = 0; n < 600; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end
        applyStimulus(0, 3'd0, 16'h0000, 3'd0, 3'd0, 0, 0);
        @(negedge clk);
        #1;
        checking = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/regfile_ckpt.md
Name: regfile_ckpt

Overview:
- Parametrised successor to the fixed 16-bit enabled register: an array of NUM_REGS registers, each WIDTH bits wide.
- Provides one write port, two combinational read ports, optional write-through bypass, optional hardwired-zero register 0, and a single-level checkpoint (save/restore) of the whole array.
- Sits in the decode stage as the CPU register file; checkpoint supports branch/exception rollback.

Parameters:
- WIDTH, 16, bits per register.
- NUM_REGS, 8, number of architectural registers (>=2; need not be a power of 2).
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see only stored values.
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes.
- Local: AW = clog2(NUM_REGS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write register index.
- wr_data  in  WIDTH  write data.
- rd_addr0  in  AW  read port 0 index.
- rd_data0  out  WIDTH  read port 0 data, combinational.
- rd_addr1  in  AW  read port 1 index.
- rd_data1  out  WIDTH  read port 1 data, combinational.
- ckpt_save  in  1  copy array into shadow at this edge.
- ckpt_restore  in  1  copy shadow into array at this edge.
- ckpt_valid  out  1  shadow holds a saved image.
- err  out  1  registered one-cycle error pulse.

Behaviour:
- Reset (rst=0, asynchronous): all registers, all shadow entries, ckpt_valid and err go to 0 immediately; held while rst=0. Release takes effect at the next clk edge.
- Effective write: wr_en=1, wr_addr<NUM_REGS, not (ZERO_REG and wr_addr==0), and no effective restore this cycle. An effective write updates reg[wr_addr] at the rising edge. Latency 1 cycle to stored value.
- Read: rd_dataN = reg[rd_addrN].
  - rd_addrN>=NUM_REGS -> 0.
  - ZERO_REG and rd_addrN==0 -> 0.
  - BYPASS=1 and an effective write with wr_addr==rd_addrN -> wr_data (same cycle).
  - Both ports are independent; both may hit the bypass at once.
- Effective restore: ckpt_restore=1, ckpt_valid=1, ckpt_save=0. At the edge, reg[i] <= shadow[i] for all i. Any same-cycle write is dropped, so no bypass occurs. ckpt_valid stays 1; the shadow is reusable.
- Effective save: ckpt_save=1, ckpt_restore=0. At the edge, shadow[i] <= the value reg[i] holds after this edge, i.e. a same-cycle effective write is included in the image. ckpt_valid <= 1. A second save overwrites the image.
- save=1 and restore=1 together: both ignored; the write still proceeds if otherwise effective; err pulses.
- err <= 1 for exactly the cycle after any of:
  - wr_en=1 with wr_addr>=NUM_REGS (write dropped);
  - ckpt_restore=1 with ckpt_valid=0 (restore ignored, write proceeds);
  - simultaneous save+restore.
  Otherwise err <= 0. A write to reg 0 with ZERO_REG=1 is silently ignored, not an error.
- Reset mid-operation: a pending save/restore/write in the reset cycle is discarded; the shadow is cleared and ckpt_valid=0.
- Register with wr_en=0 holds its value indefinitely, matching the prior enabled-register behaviour per entry.

Test Plan:
- Reset, then write reg3=0xBEEF, next cycle read rd_addr0=3 -> 0xBEEF. With BYPASS=1 the same-cycle read returns 0xBEEF; with BYPASS=0 it returns 0x0000.
- Write reg1=0x1111 and save in the same cycle, then write reg1=0x2222, then restore -> rd reg1=0x1111, ckpt_valid=1.
- Restore with ckpt_valid=0 plus write reg2=0x00AA -> err=1 next cycle, reg2=0x00AA, other registers unchanged.
- NUM_REGS=6: write addr 7 -> err pulse, no register changes; rd_addr1=7 -> 0x0000.
- ZERO_REG=1: write reg0=0xFFFF -> rd reg0=0x0000, err=0. Assert save+restore together -> err=1, shadow unchanged.
- Populate registers, save, pull rst low mid-cycle -> outputs 0 asynchronously. After release, ckpt_valid=0 and all reads return 0.
